// File: rtl/mem_pkg.sv
// Shared types and default geometry for the backing memory block.
package mem_pkg;

  // Request lifecycle: accept in IDLE, count down in WAIT, pulse in RESP.
  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_RESP = 2'd2
  } mem_state_t;

  localparam int WORD_W      = 32;
  localparam int LINE_WORDS  = 4;
  localparam int LINE_ADDR_W = 10;
  localparam int LATENCY     = 4;
  localparam int LINE_W      = WORD_W * LINE_WORDS;

endpackage

// File: rtl/mem_line_array.sv
// Line-wide storage: one synchronous write port, one combinational read port.
// Contents are deliberately not reset.
module mem_line_array #(
  parameter int LINE_W = 128,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LINE_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [LINE_W-1:0] rd_data
);

  logic [LINE_W-1:0] lines [2**ADDR_W];

  // Commit a whole line on the write strobe.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      lines[wr_addr] <= wr_data;
    end
  end

  assign rd_data = lines[rd_addr];

endmodule

// File: rtl/main_mem_block.sv
// Fixed-latency line memory serving cache fills and write-backs, one request
// at a time, finishing each with a single-cycle response pulse.
module main_mem_block #(
  parameter  int WORD_W      = mem_pkg::WORD_W,
  parameter  int LINE_WORDS  = mem_pkg::LINE_WORDS,
  parameter  int LINE_ADDR_W = mem_pkg::LINE_ADDR_W,
  parameter  int LATENCY     = mem_pkg::LATENCY,
  localparam int LINE_W      = WORD_W * LINE_WORDS
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [LINE_ADDR_W-1:0] req_line_addr,
  input  logic [LINE_W-1:0]      wr_line,
  output logic                   rsp_valid,
  output logic [LINE_W-1:0]      rd_line,
  output logic                   busy
);

  import mem_pkg::*;

  mem_state_t             state;
  mem_state_t             state_next;
  logic [3:0]             cnt;
  logic [3:0]             cnt_next;
  logic                   accept;
  logic                   lat_we;
  logic [LINE_ADDR_W-1:0] lat_addr;
  logic [LINE_W-1:0]      lat_data;
  logic [LINE_W-1:0]      arr_data;
  logic [LINE_W-1:0]      rd_hold;
  logic                   fill_load;
  logic                   commit;

  assign accept    = (state == MEM_IDLE) && req_valid;
  // The last WAIT cycle is the edge entering RESP: fill data is captured there.
  assign fill_load = (state == MEM_WAIT) && (cnt == 4'd1) && !lat_we;
  // Leaving RESP is the write commit point; reset drops state and so the write.
  assign commit    = (state == MEM_RESP) && lat_we;

  // State and countdown registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= MEM_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Capture every request field at acceptance so later input changes are inert.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      lat_we   <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
    end else if (accept) begin
      lat_we   <= req_we;
      lat_addr <= req_line_addr;
      lat_data <= wr_line;
    end
  end

  // Fill data register, held until the next read response.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rd_hold <= '0;
    end else if (fill_load) begin
      rd_hold <= arr_data;
    end
  end

  // Next-state and countdown logic.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      MEM_IDLE: begin
        if (req_valid) begin
          state_next = MEM_WAIT;
          cnt_next   = 4'(LATENCY - 1);
        end
      end
      MEM_WAIT: begin
        if (cnt == 4'd1) begin
          state_next = MEM_RESP;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      MEM_RESP: begin
        state_next = MEM_IDLE;
      end
      default: begin
        state_next = MEM_IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  assign req_ready = (state == MEM_IDLE);
  assign busy      = !req_ready;
  assign rsp_valid = (state == MEM_RESP);
  assign rd_line   = rd_hold;

  mem_line_array #(
    .LINE_W (LINE_W),
    .ADDR_W (LINE_ADDR_W)
  ) u_array (
    .clk     (clk),
    .wr_en   (commit),
    .wr_addr (lat_addr),
    .wr_data (lat_data),
    .rd_addr (lat_addr),
    .rd_data (arr_data)
  );

endmodule

// File: tb/tb_main_mem_block.sv
// Directed bench for main_mem_block: one LATENCY=4 instance for the functional
// sequence plus LATENCY=2 and LATENCY=15 instances for the latency extremes.
module tb_main_mem_block;

  localparam int LW = 128;
  localparam int AW = 10;
  localparam int LATS [3] = '{4, 2, 15};

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic [2:0]    valid = 3'b000;
  logic          we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [LW-1:0] wdata = '0;
  logic [2:0]    ready;
  logic [2:0]    rsp;
  logic [2:0]    busy;
  logic [LW-1:0] rd [3];

  int total = 0;
  int bad   = 0;

  localparam logic [LW-1:0] LINE_A = 128'h44444444_33333333_22222222_11111111;
  localparam logic [LW-1:0] LINE_B = 128'hBBBB0007_BBBB0006_BBBB0005_BBBB0004;
  localparam logic [LW-1:0] LINE_C = 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000;
  localparam logic [LW-1:0] LINE_D = 128'h0123ABCD_4567EF01_89AB2345_CDEF6789;
  localparam logic [LW-1:0] LINE_E = 128'h5A5A5A5A_A5A5A5A5_0F0F0F0F_F0F0F0F0;
  localparam logic [LW-1:0] DEAD   = {4{32'hDEADBEEF}};

  always #5 clk = ~clk;

  main_mem_block #(.LATENCY(4)) u_l4 (
    .clk (clk), .rst_b (rst_b), .req_valid (valid[0]), .req_ready (ready[0]),
    .req_we (we), .req_line_addr (addr), .wr_line (wdata),
    .rsp_valid (rsp[0]), .rd_line (rd[0]), .busy (busy[0])
  );

  main_mem_block #(.LATENCY(2)) u_l2 (
    .clk (clk), .rst_b (rst_b), .req_valid (valid[1]), .req_ready (ready[1]),
    .req_we (we), .req_line_addr (addr), .wr_line (wdata),
    .rsp_valid (rsp[1]), .rd_line (rd[1]), .busy (busy[1])
  );

  main_mem_block #(.LATENCY(15)) u_l15 (
    .clk (clk), .rst_b (rst_b), .req_valid (valid[2]), .req_ready (ready[2]),
    .req_we (we), .req_line_addr (addr), .wr_line (wdata),
    .rsp_valid (rsp[2]), .rd_line (rd[2]), .busy (busy[2])
  );

  // Advance to 1 time unit after the next rising edge: the start of a new cycle.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request to instance d in the current (idle) cycle and check the
  // full timeline; returns in cycle T+LATENCY+1 with the instance idle again.
  task automatic run_txn(input int d, input logic w, input logic [AW-1:0] a,
                         input logic [LW-1:0] dat, input logic [LW-1:0] exp_rd,
                         input bit scramble);
    int lat;
    lat = LATS[d];
    chk($sformatf("ready_pre_d%0d", d), LW'(ready[d]), LW'(1));
    valid[d] = 1'b1;
    we       = w;
    addr     = a;
    wdata    = dat;
    tick();
    valid[d] = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      chk($sformatf("busy_d%0d_c%0d", d, k), LW'(busy[d]), LW'(1));
      chk($sformatf("rsp_d%0d_c%0d", d, k), LW'(rsp[d]), LW'(k == lat));
      if (k == lat && !w) chk($sformatf("rd_line_d%0d_a%0d", d, a), rd[d], exp_rd);
      if (scramble) begin
        we    = 1'($urandom);
        addr  = AW'($urandom);
        wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      tick();
    end
    chk($sformatf("ready_post_d%0d", d), LW'(ready[d]), LW'(1));
    chk($sformatf("rsp_post_d%0d", d), LW'(rsp[d]), LW'(0));
    $display("txn dut=%0d lat=%0d we=%0d addr=%0d data=%h", d, lat, w, a, w ? dat : exp_rd);
  endtask

  initial begin
    // Reset held for 3 cycles, then released; all instances start idle.
    repeat (3) @(posedge clk);
    #1;
    rst_b = 1'b1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_ready_d%0d", d), LW'(ready[d]), LW'(1));
      chk($sformatf("rst_busy_d%0d", d), LW'(busy[d]), LW'(0));
      chk($sformatf("rst_rsp_d%0d", d), LW'(rsp[d]), LW'(0));
      chk($sformatf("rst_rd_d%0d", d), rd[d], '0);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("idle_rsp_c%0d", c), LW'(rsp[0]), LW'(0));
      chk($sformatf("idle_ready_c%0d", c), LW'(ready[0]), LW'(1));
    end

    // Write line 5 then read it back at the earliest legal cycle.
    run_txn(0, 1'b1, 10'd5, LINE_A, '0, 1'b0);
    run_txn(0, 1'b0, 10'd5, '0, LINE_A, 1'b0);

    // Held request: write line 3 then a read of line 7 held behind it.
    run_txn(0, 1'b1, 10'd7, LINE_B, '0, 1'b0);
    valid[0] = 1'b1;
    we       = 1'b1;
    addr     = 10'd3;
    wdata    = LINE_C;
    for (int c = 0; c <= 10; c++) begin
      chk($sformatf("held_ready_c%0d", c), LW'(ready[0]), LW'(c == 0 || c == 5 || c == 10));
      chk($sformatf("held_rsp_c%0d", c), LW'(rsp[0]), LW'(c == 4 || c == 9));
      if (c == 9) chk("held_rd_line7", rd[0], LINE_B);
      tick();
      if (c == 0) begin
        we   = 1'b0;
        addr = 10'd7;
      end
      if (c == 5) valid[0] = 1'b0;
    end
    $display("txn dut=0 held write line 3 then read line 7");
    run_txn(0, 1'b0, 10'd3, '0, LINE_C, 1'b0);

    // Inputs scrambled during WAIT must not disturb the latched request.
    run_txn(0, 1'b1, 10'd12, LINE_E, '0, 1'b1);
    run_txn(0, 1'b0, 10'd12, '0, LINE_E, 1'b1);

    // Reset during a write: line 9 is zeroed first, then the overwrite is aborted.
    run_txn(0, 1'b1, 10'd9, '0, '0, 1'b0);
    run_txn(0, 1'b0, 10'd5, '0, LINE_A, 1'b0);
    valid[0] = 1'b1;
    we       = 1'b1;
    addr     = 10'd9;
    wdata    = DEAD;
    tick();
    valid[0] = 1'b0;
    chk("midrst_busy_c1", LW'(busy[0]), LW'(1));
    tick();
    rst_b = 1'b0;
    #1;
    chk("midrst_rd_clear", rd[0], '0);
    chk("midrst_rsp", LW'(rsp[0]), LW'(0));
    chk("midrst_ready", LW'(ready[0]), LW'(1));
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("inrst_rsp_c%0d", c), LW'(rsp[0]), LW'(0));
    end
    rst_b = 1'b1;
    chk("postrst_ready", LW'(ready[0]), LW'(1));
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("postrst_rsp_c%0d", c), LW'(rsp[0]), LW'(0));
    end
    $display("txn dut=0 aborted write line 9");
    run_txn(0, 1'b0, 10'd9, '0, '0, 1'b0);

    // Latency extremes and the last line address.
    for (int d = 1; d < 3; d++) begin
      run_txn(d, 1'b1, 10'd1023, LINE_D, '0, 1'b0);
      run_txn(d, 1'b0, 10'd1023, '0, LINE_D, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the bench cannot hang.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
